// File: rtl/note_matcher_pkg.sv
// Shared game definitions: per-channel matcher state encoding and default
// song-time geometry, reused by scoring and display logic.
package note_matcher_pkg;

   localparam int DEF_TW  = 18;    // song-time width
   localparam int DEF_WIN = 4096;  // hit-window half-width in song-time units

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,  // asking for the next expected note
      ST_ARMED = 2'd1,  // holding a note, waiting for hit or expiry
      ST_DONE  = 2'd2   // channel exhausted until reset
   } ch_state_e;

endpackage

// File: rtl/note_matcher_ch.sv
// One note channel: press edge detect, REQ/ARMED/DONE sequencer, saturating
// hit-window compare and registered trigger outputs.
module note_matcher_ch
   import note_matcher_pkg::*;
#(
   parameter int TW  = DEF_TW,
   parameter int WIN = DEF_WIN
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [TW-1:0] song_time,
   input  logic          note_in,
   output logic          meta_req,
   input  logic          meta_valid,
   input  logic [TW-1:0] meta_time,
   input  logic          meta_end,
   output logic          match_trigger,
   output logic          miss_trigger,
   output logic          stray_trigger,
   output logic [TW-1:0] match_time,
   output logic          done
);

   localparam logic [TW:0] MAX_T = {1'b0, {TW{1'b1}}};
   localparam logic [TW:0] WIN_X = (TW+1)'(WIN);

   ch_state_e     state, state_nx;
   logic [TW-1:0] note_time, note_time_nx;
   logic [TW-1:0] match_time_nx;
   logic          match_nx, miss_nx, stray_nx;

   logic          note_q, note_prev, primed, press;
   logic [TW:0]   nt_x, st_x, lo, hi, hi_sum;
   logic          in_win, expired;

   // Edge register; on the first cycle out of reset the baseline is loaded
   // straight from note_in so a key held through reset never reads as a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         note_q    <= 1'b0;
         note_prev <= 1'b0;
         primed    <= 1'b0;
      end else begin
         note_q    <= note_in;
         note_prev <= primed ? note_q : note_in;
         primed    <= 1'b1;
      end
   end

   assign press = note_q & ~note_prev;

   // Window bounds in TW+1 bits, clamped to [0, 2^TW-1] so edge notes never wrap.
   assign nt_x    = {1'b0, note_time};
   assign st_x    = {1'b0, song_time};
   assign lo      = (nt_x >= WIN_X) ? (nt_x - WIN_X) : '0;
   assign hi_sum  = nt_x + WIN_X;
   assign hi      = (hi_sum > MAX_T) ? MAX_T : hi_sum;
   assign in_win  = (st_x >= lo) && (st_x <= hi);
   assign expired = (st_x > hi);

   // Next-state and next-output decode; a press inside the window wins over expiry.
   always_comb begin
      state_nx      = state;
      note_time_nx  = note_time;
      match_time_nx = match_time;
      match_nx      = 1'b0;
      miss_nx       = 1'b0;
      stray_nx      = 1'b0;
      case (state)
         ST_REQ: begin
            stray_nx = press;
            if (meta_valid && meta_req) begin
               if (meta_end) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx     = ST_ARMED;
                  note_time_nx = meta_time;
               end
            end
         end
         ST_ARMED: begin
            if (press && in_win) begin
               match_nx      = 1'b1;
               match_time_nx = song_time;
               state_nx      = ST_REQ;
            end else if (expired) begin
               miss_nx  = 1'b1;
               stray_nx = press;  // a late press has no note left to claim
               state_nx = ST_REQ;
            end else begin
               stray_nx = press;  // early press, note stays armed
            end
         end
         ST_DONE: begin
            stray_nx = press;
         end
         default: begin
            state_nx = ST_REQ;
         end
      endcase
   end

   // State and registered outputs; meta_req/done follow the next state so they
   // are low during reset and track the FSM one edge later.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_REQ;
         note_time     <= '0;
         match_time    <= '0;
         match_trigger <= 1'b0;
         miss_trigger  <= 1'b0;
         stray_trigger <= 1'b0;
         meta_req      <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_nx;
         note_time     <= note_time_nx;
         match_time    <= match_time_nx;
         match_trigger <= match_nx;
         miss_trigger  <= miss_nx;
         stray_trigger <= stray_nx;
         meta_req      <= (state_nx == ST_REQ);
         done          <= (state_nx == ST_DONE);
      end
   end

endmodule

// File: rtl/note_matcher_array.sv
// Array of independent note channels; only replication and bus slicing here.
module note_matcher_array
   import note_matcher_pkg::*;
#(
   parameter int N_CH = 37,
   parameter int TW   = DEF_TW,
   parameter int WIN  = DEF_WIN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [TW-1:0]      song_time,
   input  logic [N_CH-1:0]    note_in,
   output logic [N_CH-1:0]    meta_req,
   input  logic [N_CH-1:0]    meta_valid,
   input  logic [N_CH*TW-1:0] meta_time,
   input  logic [N_CH-1:0]    meta_end,
   output logic [N_CH-1:0]    match_trigger,
   output logic [N_CH-1:0]    miss_trigger,
   output logic [N_CH-1:0]    stray_trigger,
   output logic [N_CH*TW-1:0] match_time,
   output logic [N_CH-1:0]    done
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      note_matcher_ch #(
         .TW  (TW),
         .WIN (WIN)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .song_time     (song_time),
         .note_in       (note_in[i]),
         .meta_req      (meta_req[i]),
         .meta_valid    (meta_valid[i]),
         .meta_time     (meta_time[TW*i +: TW]),
         .meta_end      (meta_end[i]),
         .match_trigger (match_trigger[i]),
         .miss_trigger  (miss_trigger[i]),
         .stray_trigger (stray_trigger[i]),
         .match_time    (match_time[TW*i +: TW]),
         .done          (done[i])
      );
   end

endmodule

// File: tb/tb_note_matcher_array.sv
// Directed + randomized bench for note_matcher_array with a behavioural model.
module tb_note_matcher_array;

   localparam int N_CH = 37;
   localparam int TW   = 18;
   localparam int WIN  = 4096;
   localparam int MAXT = (1 << TW) - 1;
   localparam int BW   = N_CH * TW;
   typedef logic [BW-1:0] wv_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [TW-1:0]      song_time;
   logic [N_CH-1:0]    note_in, meta_valid, meta_end;
   logic [BW-1:0]      meta_time;
   logic [N_CH-1:0]    meta_req, match_trigger, miss_trigger, stray_trigger, done;
   logic [BW-1:0]      match_time;

   note_matcher_array #(.N_CH(N_CH), .TW(TW), .WIN(WIN)) dut (
      .clk(clk), .reset(reset), .song_time(song_time), .note_in(note_in),
      .meta_req(meta_req), .meta_valid(meta_valid), .meta_time(meta_time),
      .meta_end(meta_end), .match_trigger(match_trigger),
      .miss_trigger(miss_trigger), .stray_trigger(stray_trigger),
      .match_time(match_time), .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: a channel either holds a note (m_arm) or is exhausted (m_done).
   // A key-down seen between consecutive cycles is acted on one cycle later.
   int unsigned     m_nt[N_CH];
   int unsigned     m_mt[N_CH];
   bit              m_arm[N_CH], m_done[N_CH], m_pend[N_CH], m_prev[N_CH];
   bit              m_fresh;
   logic [N_CH-1:0] e_req, e_match, e_miss, e_stray, e_done;
   logic [BW-1:0]   e_mt;

   bit sb_on = 0;
   int arm_cnt[N_CH], ev_cnt[N_CH];
   int both_cnt = 0;

   task automatic chk(input string tag, input wv_t obs, input wv_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic set_mt(input int ch, input int unsigned t);
      meta_time[ch*TW +: TW] = TW'(t);
   endtask

   task automatic model_step();
      logic [N_CH-1:0] req_seen;
      int              st, lo, hi;
      bit              pr;
      req_seen = e_req;
      st       = int'(song_time);
      e_match  = '0;
      e_miss   = '0;
      e_stray  = '0;
      if (reset) begin
         for (int c = 0; c < N_CH; c++) begin
            m_arm[c] = 0; m_done[c] = 0; m_pend[c] = 0; m_mt[c] = 0; m_nt[c] = 0;
         end
         e_req = '0; e_done = '0; e_mt = '0; m_fresh = 1;
         return;
      end
      for (int c = 0; c < N_CH; c++) begin
         pr = m_pend[c];
         if (m_done[c]) begin
            e_stray[c] = pr;
         end else if (!m_arm[c]) begin
            e_stray[c] = pr;
            if (meta_valid[c] && req_seen[c]) begin
               if (meta_end[c]) m_done[c] = 1;
               else begin
                  m_arm[c] = 1;
                  m_nt[c]  = int'(meta_time[c*TW +: TW]);
                  if (sb_on) arm_cnt[c]++;
               end
            end
         end else begin
            lo = int'(m_nt[c]) - WIN; if (lo < 0) lo = 0;
            hi = int'(m_nt[c]) + WIN; if (hi > MAXT) hi = MAXT;
            if (pr && st >= lo && st <= hi) begin
               e_match[c] = 1; m_mt[c] = st; m_arm[c] = 0;
            end else if (st > hi) begin
               e_miss[c] = 1; e_stray[c] = pr; m_arm[c] = 0;
            end else begin
               e_stray[c] = pr;
            end
         end
         e_req[c]  = !m_arm[c] && !m_done[c];
         e_done[c] = m_done[c];
         e_mt[c*TW +: TW] = TW'(m_mt[c]);
         m_pend[c] = m_fresh ? 1'b0 : (note_in[c] && !m_prev[c]);
         m_prev[c] = note_in[c];
      end
      m_fresh = 0;
   endtask

   // One clock: predict, step, compare every output, then drop one-shot inputs.
   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("meta_req",   wv_t'(meta_req),      wv_t'(e_req));
      chk("match_trig", wv_t'(match_trigger), wv_t'(e_match));
      chk("miss_trig",  wv_t'(miss_trigger),  wv_t'(e_miss));
      chk("stray_trig", wv_t'(stray_trigger), wv_t'(e_stray));
      chk("done",       wv_t'(done),          wv_t'(e_done));
      chk("match_time", match_time,           e_mt);
      if (sb_on) begin
         for (int c = 0; c < N_CH; c++) begin
            ev_cnt[c] += int'(match_trigger[c]) + int'(miss_trigger[c]);
            if (match_trigger[c] && miss_trigger[c]) both_cnt++;
         end
      end
      meta_valid = '0;
      meta_end   = '0;
   endtask

   initial begin
      reset = 1'b1; song_time = '0; note_in = '0; meta_valid = '0;
      meta_end = '0; meta_time = '0;
      e_req = '0; e_match = '0; e_miss = '0; e_stray = '0; e_done = '0; e_mt = '0;
      m_fresh = 1;
      for (int c = 0; c < N_CH; c++) begin
         m_prev[c] = 0; arm_cnt[c] = 0; ev_cnt[c] = 0;
      end

      // Reset with a key held on ch9 across release
      note_in[9] = 1'b1;
      repeat (3) cyc();
      chk("rst_outs", wv_t'(meta_req | match_trigger | miss_trigger | stray_trigger | done), '0);
      chk("rst_mtime", match_time, '0);
      reset = 1'b0;
      cyc();
      chk("req_after_rst", wv_t'(meta_req), wv_t'({N_CH{1'b1}}));
      cyc();
      chk("held_no_press", wv_t'(stray_trigger[9]), '0);

      // Note at time 0 and ch0 note at 500, both armed at song_time 0
      meta_valid[1] = 1'b1; set_mt(1, 0);
      meta_valid[0] = 1'b1; set_mt(0, 500);
      cyc();
      note_in[1] = 1'b1;
      cyc(); cyc();
      chk("t0_match", wv_t'(match_trigger[1]), wv_t'(1));
      note_in[1] = 1'b0;
      cyc();

      // Expiry sweep: 4596 is still in window, 4597 is a miss
      for (int t = 4590; t <= 4600; t++) begin
         song_time = TW'(t);
         cyc();
         if (t == 4596) chk("miss_at_4596", wv_t'(miss_trigger[0]), '0);
         if (t == 4597) chk("miss_at_4597", wv_t'(miss_trigger[0]), wv_t'(1));
      end

      // Hit on ch3 at 9000 against note 10000
      song_time = TW'(4700);
      meta_valid[3] = 1'b1; set_mt(3, 10000);
      cyc();
      song_time = TW'(9000);
      note_in[3] = 1'b1;
      cyc(); cyc();
      chk("hit_pulse", wv_t'(match_trigger[3]), wv_t'(1));
      chk("hit_time", wv_t'(match_time[3*TW +: TW]), wv_t'(9000));
      chk("hit_req", wv_t'(meta_req[3]), wv_t'(1));
      note_in[3] = 1'b0;
      cyc();
      chk("hit_once", wv_t'(match_trigger[3]), '0);

      // Early press on ch5 is stray and keeps the note, then a real hit
      song_time = TW'(9100);
      meta_valid[5] = 1'b1; set_mt(5, 20000);
      cyc();
      song_time = TW'(15000);
      note_in[5] = 1'b1;
      cyc(); cyc();
      chk("early_stray", wv_t'(stray_trigger[5]), wv_t'(1));
      chk("early_armed", wv_t'(meta_req[5]), '0);
      note_in[5] = 1'b0;
      cyc();
      song_time = TW'(16000);
      note_in[5] = 1'b1;
      cyc(); cyc();
      chk("late_hit", wv_t'(match_trigger[5]), wv_t'(1));
      chk("late_hit_time", wv_t'(match_time[5*TW +: TW]), wv_t'(16000));
      note_in[5] = 1'b0;
      cyc();

      // End of channel 7, then a press there is stray
      song_time = TW'(17000);
      meta_valid[7] = 1'b1; meta_end[7] = 1'b1;
      cyc();
      chk("done7", wv_t'(done[7]), wv_t'(1));
      note_in[7] = 1'b1;
      cyc(); cyc();
      chk("done_stray", wv_t'(stray_trigger[7]), wv_t'(1));
      note_in[7] = 1'b0;

      // Mid-operation reset with ch2 armed and ch4 held down
      meta_valid[2] = 1'b1; set_mt(2, 30000);
      cyc();
      note_in[4] = 1'b1;
      cyc(); cyc();
      reset = 1'b1;
      cyc(); cyc();
      chk("mid_rst_outs", wv_t'(meta_req | match_trigger | miss_trigger | stray_trigger | done), '0);
      reset = 1'b0;
      cyc();
      chk("mid_rst_req", wv_t'(meta_req), wv_t'({N_CH{1'b1}}));
      cyc(); cyc();
      chk("mid_rst_nostray", wv_t'(stray_trigger[4]), '0);

      // All channels under random notes and presses, scoreboarded
      song_time = TW'(40000);
      sb_on = 1;
      for (int n = 0; n < 3000; n++) begin
         song_time = song_time + TW'($urandom_range(0, 30));
         for (int c = 0; c < N_CH; c++) begin
            if (e_req[c] && $urandom_range(0, 3) == 0) begin
               meta_valid[c] = 1'b1;
               set_mt(c, int'(song_time) + $urandom_range(200, 15000));
            end
            if ($urandom_range(0, 7) == 0) note_in[c] = ~note_in[c];
         end
         cyc();
      end
      note_in = '0;
      for (int n = 0; n < 450; n++) begin
         song_time = song_time + TW'(50);
         cyc();
      end
      sb_on = 0;
      for (int c = 0; c < N_CH; c++)
         chk($sformatf("sb_ch%0d", c), wv_t'(ev_cnt[c]), wv_t'(arm_cnt[c]));
      chk("match_miss_overlap", wv_t'(both_cnt), '0);

      // Note near the top of song time never expires when time saturates
      song_time = TW'(MAXT - 200);
      meta_valid[10] = 1'b1; set_mt(10, MAXT + 1 - 100);
      cyc();
      song_time = TW'(MAXT);
      repeat (20) cyc();
      chk("top_no_miss", wv_t'(meta_req[10]), '0);
      note_in[10] = 1'b1;
      cyc(); cyc();
      chk("top_hit", wv_t'(match_trigger[10]), wv_t'(1));
      chk("top_hit_time", wv_t'(match_time[10*TW +: TW]), wv_t'(MAXT));
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/note_matcher_array.md
NOTE_MATCHER_ARRAY -- requirements
Module: note_matcher_array

Interface
REQ-001 Parameters SHALL be:
- N_CH, default 37, number of note channels.
- TW, default 18, width of song time.
- WIN, default 4096, half-width of the hit window in song-time units.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high.
- song_time, in, TW, current song position, monotonic non-decreasing.
- note_in, in, N_CH, level per channel, 1 = key/fret held.
- meta_req, out, N_CH, per-channel request for the next expected note.
- meta_valid, in, N_CH, per-channel acknowledge, meta_time/meta_end are valid.
- meta_time, in, N_CH*TW, per-channel expected note time; channel i at bits [TW*i+TW-1:TW*i].
- meta_end, in, N_CH, per-channel flag, no further notes on this channel.
- match_trigger, out, N_CH, one-cycle pulse, hit accepted.
- miss_trigger, out, N_CH, one-cycle pulse, expected note expired unplayed.
- stray_trigger, out, N_CH, one-cycle pulse, press with no armed note in window.
- match_time, out, N_CH*TW, per-channel song_time captured at the accepted hit; same packing as meta_time.
- done, out, N_CH, channel has received meta_end.

Function
REQ-003 Edge detect: each channel SHALL register note_in; press = note_in & ~prev; only 0->1 transitions count, and holding the input SHALL produce no further presses.
REQ-004 Each channel SHALL run an independent FSM with states REQ, ARMED, DONE.
REQ-005 REQ: meta_req SHALL be high.
- meta_valid with meta_end=1 -> DONE.
- meta_valid with meta_end=0 -> latch meta_time, go to ARMED; meta_req SHALL drop in the cycle after meta_valid.
- meta_valid while meta_req is low SHALL be ignored.
REQ-006 ARMED, hit: a press with note_time - WIN <= song_time <= note_time + WIN SHALL cause the following, then -> REQ:
- match_trigger pulses the next cycle.
- match_time is loaded with song_time.
REQ-007 ARMED, miss: song_time > note_time + WIN with no qualifying press SHALL pulse miss_trigger the next cycle, then -> REQ.
REQ-008 ARMED, early press: a press with song_time < note_time - WIN SHALL pulse stray_trigger; the state SHALL remain ARMED.
REQ-009 Simultaneous press and expiry evaluation in one cycle: the inclusive window test SHALL decide; a hit takes priority, and miss and match SHALL never pulse together.
REQ-010 A press in REQ or DONE SHALL pulse stray_trigger.
REQ-011 DONE SHALL be absorbing until reset:
- done = 1.
- meta_req = 0.
- All presses produce stray only.
REQ-012 Window arithmetic SHALL use TW+1 bits with saturation:
- note_time - WIN clamps at 0.
- note_time + WIN clamps at 2^TW-1.
- A note at time 0 or near maximum SHALL never wrap.
REQ-013 All trigger outputs SHALL be registered, one-cycle pulses; latency from press sample to match_trigger SHALL be 2 cycles from the note_in change (1 edge register + 1 output register).
REQ-014 match_time SHALL hold its value until the next hit on that channel.

Reset
REQ-015 While reset is high, the following SHALL all be 0, and every FSM SHALL be in REQ:
- meta_req, match_trigger, miss_trigger, stray_trigger, match_time, done.
- The edge register.
- The latched note_time.
REQ-016 meta_req SHALL first assert the cycle after reset deasserts.
REQ-017 Reset asserted mid-operation (ARMED or DONE) SHALL return the channel to REQ with no trigger pulse.
REQ-018 A note held through reset release SHALL NOT produce a press, because the edge register loads note_in the first cycle after reset.

Structure
REQ-019 The FSM state encoding and the default TW/WIN values SHALL live in the shared game package, for reuse by the scoring and display blocks.
REQ-020 Per-channel logic SHALL be one sub-module, note_matcher_ch, instantiated N_CH times by generate.
REQ-021 note_matcher_array SHALL contain only the replication and the bit-slicing of the packed buses.

Verification
REQ-022 Hit: reset, then meta_valid ch3 with meta_time=10000; press ch3 at song_time=9000 (WIN=4096) -> match_trigger[3] pulses once, match_time ch3=9000, meta_req[3] re-asserts.
REQ-023 Miss: ch0 armed at meta_time=500, no press, song_time sweeps to 4597 -> miss_trigger[0] single pulse; no pulse at 4596.
REQ-024 Early press: ch5 armed at meta_time=20000, press at song_time=15000 -> stray_trigger[5] pulses and the channel stays ARMED; a press at 16000 -> match.
REQ-025 Boundary: meta_time=0 with a press at song_time=0 -> match (no underflow); meta_time=2^18-100 with song_time held at max -> no miss.
REQ-026 End and reset: meta_end on ch7 -> done[7]=1, a press gives stray; note held high through a mid-operation reset -> no press after release, all outputs 0 during reset, meta_req asserts the cycle after release.
REQ-027 Concurrency: all 37 channels armed with staggered times and random presses -> per channel, exactly one of match or miss per note, checked against a scoreboard.
